// File: rtl/mux_scan_pkg.sv
// Shared types and sizing for the mux scan sampler.
package mux_scan_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } scan_state_e;

endpackage

// File: rtl/mux_settle_timer.sv
// Loadable down-counter that times the settle window on each mux channel.
// Counting stops at zero, so it never wraps.
module mux_settle_timer
    import mux_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // Load has priority over decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_sampler.sv
// Scan controller for an 8:1 select mux. It steps S through 0..7 and
// holds each channel for SETTLE+1 cycles. On the last edge of each window
// it samples f. The eight samples are packed into one byte, which is
// offered downstream over a valid/ready handshake.
//
// Build option: MUX_SCAN_CONTINUOUS_EN. When this macro is defined, a
// completed handshake restarts the scan immediately instead of returning
// to IDLE.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start, S parked at 0
// SETTLE | S held while the settle timer counts down
// SAMPLE | f captured into shift bit S, then advance or finish
// DONE   | byte presented with valid=1 until ready is seen
module mux_scan_sampler
    import mux_scan_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              f,
    output logic [SEL_W-1:0]  S,
    output logic [NUM_CH-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              busy
);

    localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
    // With no settle time, each channel is a single SAMPLE cycle.
    localparam scan_state_e CH_ENTRY = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    scan_state_e       state_q;
    logic [SEL_W-1:0]  sel_q;
    logic [NUM_CH-1:0] shift_q;
    logic [NUM_CH-1:0] shift_d;
    logic [NUM_CH-1:0] data_q;
    logic              valid_q;
    logic              busy_q;

    logic              tmr_load;
    logic              tmr_dec;
    logic [CNT_W-1:0]  tmr_count;
    logic              tmr_zero;
    logic              settle_last;
    logic              handshake;

    assign handshake   = valid_q && ready;
    // The window ends on the edge where the count steps from 1 to 0.
    assign settle_last = tmr_zero || (tmr_count == CNT_W'(1));

    // Shift-register image with the current sample merged in, plus timer control.
    always_comb begin
        shift_d          = shift_q;
        shift_d[sel_q]   = f;
        tmr_load         = 1'b0;
        tmr_dec          = (state_q == ST_SETTLE);
        case (state_q)
            ST_IDLE:   tmr_load = start;
            ST_SAMPLE: tmr_load = (sel_q != LAST_CH);
`ifdef MUX_SCAN_CONTINUOUS_EN
            ST_DONE:   tmr_load = handshake;
`endif
            default:   tmr_load = 1'b0;
        endcase
    end

    mux_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (SETTLE_V),
        .dec      (tmr_dec),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    // Scan sequencer with registered select, shift, byte, valid and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sel_q <= '0;
                    if (start) begin
                        shift_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CH_ENTRY;
                    end
                end
                ST_SETTLE: begin
                    if (settle_last) begin
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    shift_q <= shift_d;
                    if (sel_q == LAST_CH) begin
                        data_q  <= shift_d;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        sel_q   <= sel_q + SEL_W'(1);
                        state_q <= CH_ENTRY;
                    end
                end
                ST_DONE: begin
                    // A start seen on the handshake cycle is deliberately dropped.
                    if (handshake) begin
                        valid_q <= 1'b0;
                        sel_q   <= '0;
`ifdef MUX_SCAN_CONTINUOUS_EN
                        shift_q <= '0;
                        state_q <= CH_ENTRY;
`else
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign S     = sel_q;
    assign data  = data_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Directed bench for mux_scan_sampler: one instance with SETTLE=1 and one with SETTLE=0.
// Each instance is driven by a behavioural 8:1 mux model.
module tb_mux_scan_sampler;

    logic       clk;
    logic       rst_n;

    logic       start1, ready1, f1, valid1, busy1;
    logic [2:0] S1;
    logic [7:0] data1, w1;

    logic       start0, ready0, f0, valid0, busy0;
    logic [2:0] S0;
    logic [7:0] data0, w0;

    int total = 0;
    int bad   = 0;

    assign f1 = w1[S1];
    assign f0 = w0[S0];

    mux_scan_sampler #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .f(f1), .S(S1),
        .data(data1), .valid(valid1), .ready(ready1), .busy(busy1)
    );

    mux_scan_sampler #(.SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .f(f0), .S(S0),
        .data(data0), .valid(valid0), .ready(ready0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a SETTLE=1 scan and report the cycle after start at which valid appeared (-1 if it never did).
    task automatic scan1(input logic [7:0] w, output int lat);
        w1 = w;
        @(negedge clk);
        start1 = 1'b1;
        lat = -1;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (valid1) lat = c;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nv;
        int first;
        int second;
        logic [7:0] pat [3];
        int k;

        rst_n = 1'b0;
        start1 = 0; ready1 = 0; w1 = 8'h00;
        start0 = 0; ready0 = 0; w0 = 8'h00;
        #12;
        check("rst_S1", S1, 0);
        check("rst_data1", data1, 8'h00);
        check("rst_valid1", valid1, 0);
        check("rst_busy1", busy1, 0);
        check("rst_S0", S0, 0);
        check("rst_data0", data0, 8'h00);
        check("rst_valid0", valid0, 0);
        check("rst_busy0", busy0, 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MUX_SCAN_CONTINUOUS_EN
        // Continuous scanning: bytes every 17 cycles, each reflecting the current pattern.
        pat[0] = 8'hA6; pat[1] = 8'h3C; pat[2] = 8'h81;
        k = 0;
        w1 = pat[0];
        ready1 = 1'b1;
        @(negedge clk);
        start1 = 1'b1;
        for (int c = 0; c < 56; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (valid1) begin
                if (k < 3) begin
                    check("t6_lat", c, 16 + 17 * k);
                    check("t6_data", data1, pat[k]);
                end
                k++;
                if (k < 3) w1 = pat[k];
            end
        end
        check("t6_bytes", k, 3);
`else
        // T1: SETTLE=1, pattern A6, ready high.
        w1 = 8'hA6;
        ready1 = 1'b1;
        @(negedge clk);
        start1 = 1'b1;
        for (int c = 0; c <= 18; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            check("t1_S", S1, (c < 16) ? (c / 2) : ((c == 16) ? 7 : 0));
            check("t1_valid", valid1, (c == 16));
            check("t1_busy", busy1, (c <= 16));
            if (c == 16) check("t1_data", data1, 8'hA6);
        end

        // T2: SETTLE=0, two scans FF then 00.
        ready0 = 1'b1;
        for (int s = 0; s < 2; s++) begin
            w0 = (s == 0) ? 8'hFF : 8'h00;
            @(negedge clk);
            start0 = 1'b1;
            for (int c = 0; c <= 9; c++) begin
                @(negedge clk);
                start0 = 1'b0;
                check("t2_S", S0, (c <= 7) ? c : ((c == 8) ? 7 : 0));
                check("t2_valid", valid0, (c == 8));
                if (c >= 8) check("t2_data", data0, (s == 0) ? 8'hFF : 8'h00);
            end
        end

        // T3: hold off ready for 5 cycles; start pulses during DONE ignored.
        ready1 = 1'b0;
        scan1(8'h3C, lat);
        check("t3_lat", lat, 16);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", valid1, 1);
            check("t3_hold_data", data1, 8'h3C);
            check("t3_hold_busy", busy1, 1);
            if (i < 4) begin
                start1 = (i % 2 == 1);
            end else begin
                ready1 = 1'b1;
                start1 = 1'b1;
            end
            @(negedge clk);
        end
        check("t3_drop_valid", valid1, 0);
        check("t3_drop_busy", busy1, 0);
        check("t3_drop_S", S1, 0);
        check("t3_keep_data", data1, 8'h3C);
        start1 = 1'b0;
        @(negedge clk);
        check("t3_start_not_queued", busy1, 0);

        // T4: asynchronous reset mid-scan, then a clean full scan.
        w1 = 8'h5A;
        @(negedge clk);
        start1 = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            start1 = 1'b0;
        end
        check("t4_pre_S", S1, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_rst_S", S1, 0);
        check("t4_rst_busy", busy1, 0);
        check("t4_rst_valid", valid1, 0);
        check("t4_rst_data", data1, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (valid1) nv++;
        end
        check("t4_no_valid", nv, 0);
        check("t4_idle", busy1, 0);
        scan1(8'h5A, lat);
        check("t4_lat", lat, 16);
        check("t4_data", data1, 8'h5A);
        @(negedge clk);
        check("t4_back_idle", busy1, 0);

        // T5: start held high in single-shot mode; one byte per 18-cycle period.
        @(negedge clk);
        start1 = 1'b1;
        nv = 0; first = -1; second = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (valid1) begin
                nv++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        start1 = 1'b0;
        check("t5_bytes", nv, 4'd3);
        check("t5_first", first, 16);
        check("t5_period", second - first, 18);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
